mem_bank_ctrl: RTL

MEM_BANK_CTRL -- requirements
Module: mem_bank_ctrl

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_array.sv | 40 ++++
 rtl/mem_bank_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory bank controller: default geometry, read
// latency and the controller FSM state encoding.
package mem_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_SZ     = 8;
    localparam int DEF_DEPTH  = 2 ** DEF_SZ;
    localparam int DEF_RD_LAT = 2;

    // Wide enough for the largest legal RD_LAT of 8.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RWAIT = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage with per-byte write strobes and a registered read port.
// Contents have no reset, so they survive controller resets.
module mem_array
    import mem_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SZ    = DEF_SZ,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [SZ-1:0]        addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [WIDTH/8-1:0]   byte_en,
    output logic [WIDTH-1:0]     rd_data
);

    localparam int BE_W = WIDTH / 8;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (byte_en[i]) begin
                    mem[addr][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    // Read data is held between reads so the controller can stretch latency.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_bank_ctrl.sv
// Single-outstanding-request memory bank controller: accepts one read or write,
// range-checks it, and returns a one-cycle response after the configured latency.
module mem_bank_ctrl
    import mem_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SZ     = DEF_SZ,
    parameter int DEPTH  = 2 ** SZ,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic                 write_read_enable,
    input  logic [SZ-1:0]        address,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [WIDTH/8-1:0]   byte_en,
    output logic                 ready,
    output logic [WIDTH-1:0]     rdata,
    output logic                 resp_valid,
    output logic                 err
);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] lat_cnt;
    logic             is_write_q;
    logic             err_q;
    logic             accept;
    logic             in_range;
    logic [WIDTH-1:0] arr_rdata;

    assign accept   = valid && ready;
    // One extra bit so DEPTH == 2**SZ compares correctly.
    assign in_range = ({1'b0, address} < (SZ+1)'(DEPTH));

    mem_array #(
        .WIDTH (WIDTH),
        .SZ    (SZ),
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .wr_en   (accept && write_read_enable && in_range),
        .rd_en   (accept && !write_read_enable && in_range),
        .addr    (address),
        .wr_data (wr_data),
        .byte_en (byte_en),
        .rd_data (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ready <= 1'b0;
        end else begin
            state <= next_state;
            ready <= (next_state == IDLE);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (write_read_enable || (RD_LAT <= 1)) begin
                        next_state = RESP;
                    end else begin
                        next_state = RWAIT;
                    end
                end
            end
            RWAIT: begin
                if (lat_cnt <= CNT_W'(1)) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request attributes are frozen at acceptance; later input changes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_cnt    <= '0;
            is_write_q <= 1'b0;
            err_q      <= 1'b0;
        end else if (accept) begin
            lat_cnt    <= CNT_W'(RD_LAT - 1);
            is_write_q <= write_read_enable;
            err_q      <= !in_range;
        end else if (state == RWAIT) begin
            lat_cnt    <= lat_cnt - CNT_W'(1);
        end
    end

    assign resp_valid = (state == RESP);
    assign err        = resp_valid && err_q;
    assign rdata      = (resp_valid && !is_write_q && !err_q) ? arr_rdata : '0;

endmodule
